fifo_rd_drain: RTL and testbench

//   Read-side consumer of the async FIFO, running in the FIFO read-clock domain.

---
 rtl/fifo_rd_drain_if.sv | 26 ++
 rtl/fifo_rd_drain.sv | 120 ++++++++++++
 tb/tb_fifo_rd_drain.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_if.sv
// Signal bundle between the FIFO read port, the drain FSM and the UART transmitter.
// The master modport is the drain block's view; the slave modport is its environment.
interface fifo_rd_drain_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  en;
   logic                  rempty;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rinc;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_busy;
   logic                  tx_timeout;
   logic [CNT_WIDTH-1:0]  sent_cnt;

   modport master (
      input  en, rempty, rdata, tx_busy,
      output rinc, tx_data, tx_valid, tx_timeout, sent_cnt
   );

   modport slave (
      output en, rempty, rdata, tx_busy,
      input  rinc, tx_data, tx_valid, tx_timeout, sent_cnt
   );
endinterface

// File: rtl/fifo_rd_drain.sv
// Pops bytes from a first-word-fall-through FIFO and hands each one to a UART transmitter,
// counting delivered bytes and pulsing a timeout while the transmitter ignores a request.
module fifo_rd_drain #(
   parameter int DATA_WIDTH  = 8,
   parameter int CNT_WIDTH   = 16,
   parameter int ACK_TIMEOUT = 1024
) (
   input logic             i_rclk,
   input logic             i_rrst,
   fifo_rd_drain_if.master io_bus
);
   localparam int TO_WIDTH = $clog2(ACK_TIMEOUT);
   localparam logic [TO_WIDTH-1:0]   TO_LAST  = TO_WIDTH'(ACK_TIMEOUT - 1);
   localparam logic [TO_WIDTH-1:0]   TO_ZERO  = TO_WIDTH'(0);
   localparam logic [TO_WIDTH-1:0]   TO_ONE   = TO_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = CNT_WIDTH'(0);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_REQ  = 2'd2,
      S_BUSY = 2'd3
   } state_t;

   state_t                r_state;
   logic                  r_rinc;
   logic                  r_tx_valid;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_timeout;
   logic [TO_WIDTH-1:0]   r_to_cnt;
   logic [CNT_WIDTH-1:0]  r_sent_cnt;

   state_t                w_state_nxt;
   logic                  w_rinc_nxt;
   logic                  w_valid_nxt;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic                  w_timeout_nxt;
   logic [TO_WIDTH-1:0]   w_to_cnt_nxt;
   logic [CNT_WIDTH-1:0]  w_sent_nxt;

   // Next-state and next-output decode; every output is a register fed from here.
   always_comb begin
      w_state_nxt   = r_state;
      w_rinc_nxt    = 1'b0;
      w_valid_nxt   = r_tx_valid;
      w_data_nxt    = r_tx_data;
      w_timeout_nxt = 1'b0;
      w_to_cnt_nxt  = r_to_cnt;
      w_sent_nxt    = r_sent_cnt;
      case (r_state)
         S_IDLE: begin
            if (io_bus.en && !io_bus.rempty) begin
               w_data_nxt  = io_bus.rdata;
               w_rinc_nxt  = 1'b1;
               w_state_nxt = S_POP;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         // rempty is stale right after the pop, so POP never looks at it.
         S_POP: begin
            w_valid_nxt  = 1'b1;
            w_to_cnt_nxt = TO_ZERO;
            w_state_nxt  = S_REQ;
         end
         S_REQ: begin
            if (io_bus.tx_busy) begin
               w_valid_nxt = 1'b0;
               w_state_nxt = S_BUSY;
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout_nxt = 1'b1;
               w_to_cnt_nxt  = TO_ZERO;
            end else begin
               w_to_cnt_nxt = r_to_cnt + TO_ONE;
            end
         end
         S_BUSY: begin
            if (!io_bus.tx_busy) begin
               w_sent_nxt  = r_sent_cnt + CNT_ONE;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_BUSY;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_rclk) begin
      if (i_rrst) begin
         r_state      <= S_IDLE;
         r_rinc       <= 1'b0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= DATA_ZERO;
         r_tx_timeout <= 1'b0;
         r_to_cnt     <= TO_ZERO;
         r_sent_cnt   <= CNT_ZERO;
      end else begin
         r_state      <= w_state_nxt;
         r_rinc       <= w_rinc_nxt;
         r_tx_valid   <= w_valid_nxt;
         r_tx_data    <= w_data_nxt;
         r_tx_timeout <= w_timeout_nxt;
         r_to_cnt     <= w_to_cnt_nxt;
         r_sent_cnt   <= w_sent_nxt;
      end
   end

   assign io_bus.rinc       = r_rinc;
   assign io_bus.tx_valid   = r_tx_valid;
   assign io_bus.tx_data    = r_tx_data;
   assign io_bus.tx_timeout = r_tx_timeout;
   assign io_bus.sent_cnt   = r_sent_cnt;
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a queue-based FIFO and a UART with programmable accept delay,
// table-driven single-byte transactions, hand-written corner sequences and a random phase.
module tb_fifo_rd_drain;
   localparam int DW = 8;
   localparam int CW = 4;
   localparam int AT = 8;

   typedef struct {
      logic [7:0]    data;
      int            delay;
      int            exp_to;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   logic clk  = 1'b0;
   logic rrst = 1'b1;

   fifo_rd_drain_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACK_TIMEOUT(AT)) dut (
      .i_rclk (clk),
      .i_rrst (rrst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] inflight_q[$];
   logic [7:0] acc_q[$];
   int uart_st, uart_cnt, cur_delay, cur_hold, fixed_delay, fixed_hold;
   bit rand_uart;
   int pops, pushes, completes, timeouts, exp_timeouts, cyc, last_to_cyc, wraps;
   bit last_to_valid;
   logic [CW-1:0] prev_sent;

   task automatic check_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_fifo();
      bus.rempty = (fifo_q.size() == 0);
      bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] d);
      fifo_q.push_back(d);
      pushes++;
      drive_fifo();
   endtask

   // One clock of the environment: check pops, timeouts and sent_cnt, then run the UART.
   task automatic step();
      bit pre_en, pre_empty, pre_rinc;
      logic [CW-1:0] exp_sent;
      pre_en    = bus.en;
      pre_empty = bus.rempty;
      pre_rinc  = bus.rinc;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.rinc) begin
         check_eq("rinc_legal", {pre_en, pre_empty, pre_rinc}, 3'b100);
         if (fifo_q.size() != 0) begin
            check_eq("pop_data", bus.tx_data, fifo_q[0]);
            inflight_q.push_back(fifo_q.pop_front());
         end
         pops++;
      end
      if (bus.tx_timeout) begin
         timeouts++;
         check_eq("timeout_in_req", uart_st, 1);
         if (last_to_valid) check_eq("timeout_spacing", cyc - last_to_cyc, AT);
         last_to_valid = 1'b1;
         last_to_cyc   = cyc;
      end
      if (bus.sent_cnt != prev_sent) begin
         exp_sent = prev_sent + 4'd1;
         check_eq("sent_cnt_step", bus.sent_cnt, exp_sent);
         if (bus.sent_cnt == 4'd0) wraps++;
         prev_sent = bus.sent_cnt;
      end
      if (uart_st == 0 && bus.tx_valid) begin
         check_eq("valid_has_byte", inflight_q.size(), 1);
         cur_delay = rand_uart ? int'($urandom_range(0, 20)) : fixed_delay;
         cur_hold  = rand_uart ? int'($urandom_range(1, 3)) : fixed_hold;
         exp_timeouts += cur_delay / AT;
         uart_cnt      = 0;
         uart_st       = 1;
         last_to_valid = 1'b0;
      end
      if (uart_st == 1) begin
         if (inflight_q.size() != 0)
            check_eq("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, inflight_q[0]});
         if (uart_cnt == cur_delay) begin
            bus.tx_busy = 1'b1;
            if (inflight_q.size() != 0) acc_q.push_back(inflight_q.pop_front());
            uart_cnt = 0;
            uart_st  = 2;
         end else begin
            uart_cnt++;
         end
      end else if (uart_st == 2) begin
         uart_cnt++;
         if (uart_cnt >= cur_hold) begin
            bus.tx_busy = 1'b0;
            completes++;
            uart_st = 0;
         end
      end
      drive_fifo();
   endtask

   task automatic run_until_idle(input int max_cyc);
      int n;
      n = 0;
      while (!(((fifo_q.size() == 0) || !bus.en) && uart_st == 0 && inflight_q.size() == 0)
             && n < max_cyc) begin
         step();
         n++;
      end
      check_eq("drain_in_budget", int'(n < max_cyc), 1);
      step();
      step();
   endtask

   task automatic wait_uart(input int target, input int max_cyc);
      int n;
      n = 0;
      while (uart_st != target && n < max_cyc) begin
         step();
         n++;
      end
      check_eq("uart_state_in_budget", uart_st, target);
   endtask

   task automatic do_reset(input int n);
      rrst        = 1'b1;
      bus.tx_busy = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_eq("rst_rinc", bus.rinc, 0);
         check_eq("rst_tx_valid", bus.tx_valid, 0);
         check_eq("rst_tx_timeout", bus.tx_timeout, 0);
         check_eq("rst_sent_cnt", bus.sent_cnt, 0);
         check_eq("rst_tx_data", bus.tx_data, 0);
      end
      rrst = 1'b0;
      inflight_q.delete();
      uart_st       = 0;
      completes     = 0;
      prev_sent     = 4'd0;
      last_to_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      logic [7:0] exp2[3];
      int pops0, c0, got;
      logic [CW-1:0] exp_cnt;

      vecs = '{'{8'hAA, 20, 2, 4'd4}, '{8'h55, 0, 0, 4'd5}, '{8'h3C, 8, 1, 4'd6},
               '{8'h0F, 7, 0, 4'd7}, '{8'hF0, 16, 2, 4'd8}, '{8'h81, 9, 1, 4'd9},
               '{8'h00, 1, 0, 4'd10}, '{8'hFF, 24, 3, 4'd11}};
      exp2 = '{8'hDB, 8'hCE, 8'h91};
      bus.en = 1'b0;
      bus.tx_busy = 1'b0;
      fixed_delay = 2;
      fixed_hold  = 2;
      rand_uart   = 1'b0;
      prev_sent   = 4'd0;

      // Reset while the FIFO already offers DB.
      push(8'hDB);
      do_reset(4);

      // Three queued bytes, UART accepts 2 cycles after each request.
      push(8'hCE);
      push(8'h91);
      bus.en = 1'b1;
      run_until_idle(200);
      check_eq("t2_pops", pops, 3);
      for (int i = 0; i < 3; i++) begin
         got = (i < acc_q.size()) ? int'(acc_q[i]) : -1;
         check_eq("t2_order", got, exp2[i]);
      end
      check_eq("t2_sent_cnt", bus.sent_cnt, 3);
      repeat (10) step();
      check_eq("t2_idle_no_pop", pops, 3);

      // Single-byte transactions with varying UART accept delay.
      for (int i = 0; i < 8; i++) begin
         int to0;
         to0   = timeouts;
         pops0 = pops;
         fixed_delay = vecs[i].delay;
         push(vecs[i].data);
         run_until_idle(200);
         got = (acc_q.size() != 0) ? int'(acc_q[$]) : -1;
         check_eq("vec_data", got, vecs[i].data);
         check_eq("vec_timeouts", timeouts - to0, vecs[i].exp_to);
         check_eq("vec_sent_cnt", bus.sent_cnt, vecs[i].exp_cnt);
         check_eq("vec_pops", pops - pops0, 1);
      end

      // en low blocks pops; en dropped mid-request still completes that byte.
      fixed_delay = 5;
      bus.en = 1'b0;
      push(8'h11);
      push(8'h22);
      pops0 = pops;
      repeat (50) step();
      check_eq("en0_no_pop", pops - pops0, 0);
      bus.en = 1'b1;
      wait_uart(1, 20);
      bus.en = 1'b0;
      c0 = completes;
      run_until_idle(200);
      check_eq("en_drop_pops", pops - pops0, 1);
      check_eq("en_drop_completes", completes - c0, 1);
      check_eq("en_drop_fifo_left", fifo_q.size(), 1);
      check_eq("en_drop_sent_cnt", bus.sent_cnt, 12);
      repeat (20) step();
      check_eq("en_drop_parked", pops - pops0, 1);
      bus.en = 1'b1;
      run_until_idle(200);
      check_eq("en_resume_sent_cnt", bus.sent_cnt, 13);

      // 17 bytes through a 4-bit counter: 15 -> 0 -> 1.
      do_reset(2);
      fixed_delay = 1;
      fixed_hold  = 1;
      wraps = 0;
      for (int i = 0; i < 17; i++) push(8'(i * 13 + 7));
      run_until_idle(17 * 30);
      check_eq("wrap_completes", completes, 17);
      check_eq("wrap_count", wraps, 1);
      check_eq("wrap_sent_cnt", bus.sent_cnt, 1);

      // Random traffic, random en, random UART timing.
      rand_uart = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) push(8'($urandom));
         bus.en = ($urandom_range(0, 9) != 0);
         drive_fifo();
         step();
      end
      bus.en = 1'b1;
      run_until_idle(3000);
      exp_cnt = CW'(completes);
      check_eq("rand_sent_cnt", bus.sent_cnt, exp_cnt);
      check_eq("rand_fifo_empty", fifo_q.size(), 0);
      check_eq("rand_pushes_popped", pops, pushes);
      check_eq("rand_timeouts", timeouts, exp_timeouts);

      // Reset while the UART is busy: byte lost, pops resume afterwards.
      rand_uart   = 1'b0;
      fixed_delay = 2;
      fixed_hold  = 10;
      push(8'h5A);
      wait_uart(2, 50);
      step();
      do_reset(1);
      fixed_hold = 2;
      push(8'hA5);
      push(8'h3C);
      run_until_idle(200);
      check_eq("post_rst_sent_cnt", bus.sent_cnt, 2);
      got = (acc_q.size() != 0) ? int'(acc_q[$]) : -1;
      check_eq("post_rst_last_byte", got, 8'h3C);
      check_eq("final_timeouts", timeouts, exp_timeouts);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
